// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, branch decision and target; EX/MEM register.
// One-cycle latency E->M; never stalls, no backpressure; FlushM bubbles the control fields only.
module execute_cycle (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_ExtE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    input  logic        FlushM,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero_e;

    logic        reg_write_q, reg_write_d;
    logic        mem_write_q, mem_write_d;
    logic        result_src_q, result_src_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_result_q;
    logic [31:0] write_data_q;
    logic [31:0] pc_plus4_q;

    // Forwarding from MEM uses the registered value, i.e. the previous instruction's result.
    always_comb begin
        src_a = RD1_E;
        unique case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        unique case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_ExtE : fwd_b;

    always_comb begin
        alu_result = 32'h0;
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'h1 : 32'h0;
            default: alu_result = 32'h0;
        endcase
    end

    assign zero_e    = (alu_result == 32'h0);
    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_ExtE;

    always_comb begin
        reg_write_d  = FlushM ? 1'b0 : RegWriteE;
        mem_write_d  = FlushM ? 1'b0 : MemWriteE;
        result_src_d = FlushM ? 1'b0 : ResultSrcE;
        rd_d         = FlushM ? 5'd0 : RD_E;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= 5'd0;
            alu_result_q <= 32'h0;
            write_data_q <= 32'h0;
            pc_plus4_q   <= 32'h0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result;
            write_data_q <= fwd_b;
            pc_plus4_q   <= PCPlus4E;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed table of EX-stage vectors with hand-computed results, plus reset sequences.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        FlushM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_ExtE(Imm_ExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
        .ForwardB_E(ForwardB_E), .ResultW(ResultW), .FlushM(FlushM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    typedef struct {
        logic        regw, alusrc, memw, ressrc, branch;
        logic [2:0]  ctl;
        logic [1:0]  fa, fb;
        logic        flush;
        logic [31:0] rd1, rd2, imm, pc, pc4, resw;
        logic [4:0]  rd;
        logic        e_pcsrc;
        logic [31:0] e_tgt, e_alu, e_wd;
        logic        e_regw, e_memw, e_res;
        logic [4:0]  e_rd;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        RegWriteE = v.regw;  ALUSrcE = v.alusrc; MemWriteE = v.memw;
        ResultSrcE = v.ressrc; BranchE = v.branch; ALUControlE = v.ctl;
        ForwardA_E = v.fa;   ForwardB_E = v.fb;  FlushM = v.flush;
        RD1_E = v.rd1; RD2_E = v.rd2; Imm_ExtE = v.imm; PCE = v.pc;
        PCPlus4E = v.pc4; ResultW = v.resw; RD_E = v.rd;
    endtask

    task automatic chk_m(input string tag, input vec_t v);
        chk({tag, ".ALUResultM"}, ALUResultM, v.e_alu);
        chk({tag, ".WriteDataM"}, WriteDataM, v.e_wd);
        chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, v.e_regw});
        chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, v.e_memw});
        chk({tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, {31'd0, v.e_res});
        chk({tag, ".RD_M"},       {27'd0, RD_M}, {27'd0, v.e_rd});
        chk({tag, ".PCPlus4M"},   PCPlus4M, v.e_pc4);
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".ALUResultM"}, ALUResultM, 32'h0);
        chk({tag, ".WriteDataM"}, WriteDataM, 32'h0);
        chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, 32'h0);
        chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, 32'h0);
        chk({tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, 32'h0);
        chk({tag, ".RD_M"},       {27'd0, RD_M}, 32'h0);
        chk({tag, ".PCPlus4M"},   PCPlus4M, 32'h0);
    endtask

    initial begin
        // regw alusrc memw ressrc branch ctl fa fb flush | rd1 rd2 imm pc pc4 resw rd
        //   | e_pcsrc e_tgt e_alu e_wd e_regw e_memw e_res e_rd e_pc4
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,1'b0,
                     32'd5,32'd0,32'd7,32'h0,32'h4,32'h0,5'd3,
                     1'b0,32'h7,32'd12,32'd0,1'b1,1'b0,1'b0,5'd3,32'h4};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'b001,2'b00,2'b00,1'b0,
                     32'd9,32'd9,32'hFFFF_FFF8,32'h100,32'h104,32'h0,5'd0,
                     1'b1,32'hF8,32'd0,32'd9,1'b0,1'b0,1'b0,5'd0,32'h104};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,1'b0,
                     32'd15,32'h55,32'd5,32'h200,32'h204,32'h0,5'd5,
                     1'b0,32'h205,32'd20,32'h55,1'b1,1'b0,1'b0,5'd5,32'h204};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,3'b001,2'b10,2'b01,1'b0,
                     32'hDEAD,32'hBEEF,32'h10,32'h300,32'h304,32'd4,5'd6,
                     1'b0,32'h310,32'd16,32'd4,1'b1,1'b1,1'b1,5'd6,32'h304};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,3'b010,2'b00,2'b00,1'b1,
                     32'hF0F0_F0F0,32'hFF00_FF00,32'h0,32'h0,32'h404,32'h0,5'd7,
                     1'b0,32'h0,32'hF000_F000,32'hFF00_FF00,1'b0,1'b0,1'b0,5'd0,32'h404};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b101,2'b00,2'b00,1'b0,
                     32'hFFFF_FFFF,32'h12,32'd1,32'h10,32'h14,32'h0,5'd8,
                     1'b0,32'h11,32'd1,32'h12,1'b1,1'b0,1'b0,5'd8,32'h14};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'b101,2'b00,2'b00,1'b0,
                     32'd1,32'hFFFF_FFFF,32'h8,32'h20,32'h24,32'h0,5'd9,
                     1'b1,32'h28,32'd0,32'hFFFF_FFFF,1'b1,1'b0,1'b0,5'd9,32'h24};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'b011,2'b11,2'b11,1'b0,
                     32'hF0,32'h0F,32'h8,32'hFFFF_FFFC,32'h100,32'h0,5'd10,
                     1'b0,32'h4,32'hFF,32'h0F,1'b1,1'b0,1'b0,5'd10,32'h100};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'b000,2'b01,2'b10,1'b0,
                     32'h0,32'h0,32'h40,32'h0,32'h44,32'hFFFF_FF01,5'd11,
                     1'b1,32'h40,32'h0,32'hFF,1'b1,1'b0,1'b0,5'd11,32'h44};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'b111,2'b00,2'b00,1'b0,
                     32'd5,32'd3,32'h4,32'h50,32'h54,32'h0,5'd12,
                     1'b0,32'h54,32'h0,32'd3,1'b1,1'b0,1'b0,5'd12,32'h54};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'b001,2'b00,2'b00,1'b0,
                     32'h0,32'd7,32'd1,32'h60,32'h64,32'h0,5'd13,
                     1'b0,32'h61,32'hFFFF_FFFF,32'd7,1'b1,1'b0,1'b0,5'd13,32'h64};

        reset = 1'b0;
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_ExtE = 0; PCE = 0;
        PCPlus4E = 0; ResultW = 0; RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; FlushM = 0;
        #1;
        chk_m_zero("reset0");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.PCSrcE", i), {31'd0, PCSrcE}, {31'd0, vecs[i].e_pcsrc});
            chk($sformatf("v%0d.PCTargetE", i), PCTargetE, vecs[i].e_tgt);
            @(posedge clk);
            #1;
            chk_m($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges while M outputs hold v10 values.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_m_zero("async_rst");
        chk("rst.PCTargetE", PCTargetE, 32'h61);
        PCE = 32'h1000; Imm_ExtE = 32'h20;
        #1;
        chk("rst.PCTargetE2", PCTargetE, 32'h1020);
        @(posedge clk);
        #1;
        chk_m_zero("rst_hold");

        @(negedge clk);
        reset = 1'b1;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        chk_m("post_rst", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, each 1 bit: ID/EX control bits from the decode stage.
REQ-004 SHALL have input ALUControlE, 3 bits: ALU operation select.
REQ-005 SHALL have inputs RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, each 32 bits: ID/EX operand, immediate and PC values.
REQ-006 SHALL have input RD_E, 5 bits: destination register index.
REQ-007 SHALL have inputs ForwardA_E and ForwardB_E, each 2 bits: operand source selects from the hazard unit.
REQ-008 SHALL have input ResultW, 32 bits: writeback result for forwarding.
REQ-009 SHALL have input FlushM, 1 bit: kill the instruction entering EX/MEM.
REQ-010 SHALL have outputs PCSrcE (1 bit) and PCTargetE (32 bits): combinational branch decision and branch target.
REQ-011 SHALL have outputs RegWriteM, MemWriteM, ResultSrcM (each 1 bit), RD_M (5 bits), and ALUResultM, WriteDataM, PCPlus4M (each 32 bits): the registered EX/MEM bundle.

Function
REQ-012 SrcA SHALL be selected by ForwardA_E: 00 gives RD1_E, 01 gives ResultW, 10 gives ALUResultM (the registered output), 11 gives RD1_E.
REQ-013 The forwarded B value SHALL be selected by ForwardB_E using the same encoding over RD2_E, ResultW and ALUResultM.
REQ-014 SrcB SHALL equal Imm_ExtE when ALUSrcE=1; otherwise SrcB SHALL equal the forwarded B value.
REQ-015 The ALU SHALL compute, by ALUControlE:
- 000: SrcA+SrcB
- 001: SrcA-SrcB
- 010: AND
- 011: OR
- 101: signed SrcA<SrcB gives 32'h1, otherwise 32'h0
- any other code: 32'h0
REQ-016 All ALU add/sub operations SHALL be 32-bit modulo; carry and overflow SHALL be discarded.
REQ-017 ZeroE SHALL be 1 exactly when the ALU result equals 32'h0.
REQ-018 PCSrcE SHALL equal BranchE AND ZeroE, combinationally, within the same cycle.
REQ-019 PCTargetE SHALL equal PCE+Imm_ExtE, 32-bit modulo and combinational; its value SHALL be independent of BranchE.
REQ-020 On each rising clk edge with reset high and FlushM=0, the EX/MEM register SHALL capture:
- RegWriteM from RegWriteE
- MemWriteM from MemWriteE
- ResultSrcM from ResultSrcE
- RD_M from RD_E
- ALUResultM from the ALU result
- WriteDataM from the forwarded B value
- PCPlus4M from PCPlus4E
REQ-021 Latency from the E inputs to the M outputs SHALL be exactly one cycle; there SHALL be no stall and no backpressure.
REQ-022 On a rising clk edge with FlushM=1:
- RegWriteM, MemWriteM, ResultSrcM and RD_M SHALL load 0.
- The 32-bit data fields SHALL load normally.
REQ-023 When ForwardA_E=10 or ForwardB_E=10, the value used SHALL be the current ALUResultM (the pre-edge value), not the value being computed this cycle.

Reset
REQ-024 While reset=0, every EX/MEM output SHALL be 0, immediately and asynchronously, regardless of clk.
REQ-025 A reset asserted mid-operation SHALL discard the in-flight instruction.
REQ-026 After reset deasserts, the first rising edge SHALL capture the E inputs normally.
REQ-027 PCSrcE and PCTargetE SHALL remain combinational during reset.

Verification
REQ-028 The bench SHALL cover add with immediate:
- Stimulus: ALUSrcE=1, ALUControlE=000, RD1_E=5, Imm_ExtE=7, RegWriteE=1, RD_E=3, then one edge.
- Required response: ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-029 The bench SHALL cover a taken branch:
- Stimulus: BranchE=1, ALUControlE=001, RD1_E=RD2_E=9, PCE=0x100, Imm_ExtE=0xFFFFFFF8.
- Required response, same cycle: PCSrcE=1, PCTargetE=0xF8.
REQ-030 The bench SHALL cover forwarding:
- Stimulus: ForwardA_E=10 with ALUResultM=20, ForwardB_E=01 with ResultW=4, ALUControlE=001, ALUSrcE=0.
- Required response after the edge: ALUResultM=16, WriteDataM=4.
REQ-031 The bench SHALL cover flush:
- Stimulus: FlushM=1 with MemWriteE=1, RegWriteE=1, RD_E=7.
- Required response after the edge: MemWriteM=0, RegWriteM=0, RD_M=0.
REQ-032 The bench SHALL cover SLT:
- Stimulus: ALUControlE=101, SrcA=0xFFFFFFFF, SrcB=1.
- Required response: ALUResultM=1.
- Stimulus: SrcA=1, SrcB=0xFFFFFFFF.
- Required response: ALUResultM=0.
REQ-033 The bench SHALL cover asynchronous reset:
- Stimulus: drive reset=0 between clock edges while the M outputs are nonzero.
- Required response: all M outputs are 0 before the next edge.
